// File: rtl/memcopy_pkg.sv
// Shared constants and FSM state encoding for the memcopy DMA engine.
package memcopy_pkg;

  localparam int BUS_ADDR_W = 27;
  localparam int DATA_W     = 32;
  localparam int STRIDE     = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FIN  = 3'd3,
    VFY  = 3'd4
  } state_t;

endpackage

// File: rtl/memcopy_ptr.sv
// Loadable word pointer: load forces word alignment, inc steps by one word
// and wraps modulo 2^W.
module memcopy_ptr
  import memcopy_pkg::*;
#(
  parameter int W = BUS_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);
  localparam logic [W-1:0] STEP       = W'(STRIDE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val & ALIGN_MASK;
    end else if (inc) begin
      value <= value + STEP;
    end
  end

endmodule

// File: rtl/memcopy.sv
// Word-at-a-time read-then-write block copier on the SDRAM data port.
// Define MEMCOPY_VERIFY_EN to re-read and compare every written word.
module memcopy
  import memcopy_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              data_stb,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_dout,
  input  logic [DATA_W-1:0] data_din,
  input  logic              data_ack,
  input  logic              data_timeout
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STRIDE);
  localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  remain;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              load;
  logic              advance;

  assign load = (state == IDLE) && start && (count != '0);

  // A word is finished (pointers step) once its write, or its verify read, succeeds.
  always_comb begin
    advance = 1'b0;
`ifdef MEMCOPY_VERIFY_EN
    if (state == VFY && data_ack && !data_timeout && data_din == data_dout)
      advance = 1'b1;
`else
    if (state == WR && data_ack && !data_timeout)
      advance = 1'b1;
`endif
  end

  memcopy_ptr #(.W(ADDR_W)) u_src_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (src_addr),
    .inc      (advance),
    .value    (src_ptr)
  );

  memcopy_ptr #(.W(ADDR_W)) u_dst_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (dst_addr),
    .inc      (advance),
    .value    (dst_ptr)
  );

  // FIN shows done in its first cycle when entered from a bus state; a
  // zero-length request enters FIN with done low and raises it one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remain    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= '0;
      data_stb  <= 1'b0;
      data_we   <= 1'b0;
      data_addr <= '0;
      data_dout <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error  <= 1'b0;
            busy   <= 1'b1;
            remain <= count;
            if (count != '0) begin
              state     <= RD;
              data_stb  <= 1'b1;
              data_we   <= 1'b0;
              data_addr <= src_addr & ALIGN_MASK;
            end else begin
              state <= FIN;
            end
          end
        end

        RD: begin
          if (data_timeout) begin
            error    <= 1'b1;
            err_addr <= data_addr;
            data_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else if (data_ack) begin
            data_dout <= data_din;
            data_we   <= 1'b1;
            data_addr <= dst_ptr;
            state     <= WR;
          end
        end

        WR: begin
          if (data_timeout) begin
            error    <= 1'b1;
            err_addr <= data_addr;
            data_stb <= 1'b0;
            data_we  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
`ifdef MEMCOPY_VERIFY_EN
          end else if (data_ack) begin
            data_we <= 1'b0;
            state   <= VFY;
          end
`else
          end else if (advance) begin
            remain <= remain - ONE;
            if (remain == ONE) begin
              data_stb <= 1'b0;
              data_we  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              data_we   <= 1'b0;
              data_addr <= src_ptr + STEP;
              state     <= RD;
            end
          end
`endif
        end

`ifdef MEMCOPY_VERIFY_EN
        VFY: begin
          if (data_timeout || (data_ack && !advance)) begin
            error    <= 1'b1;
            err_addr <= data_addr;
            data_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end else if (advance) begin
            remain <= remain - ONE;
            if (remain == ONE) begin
              data_stb <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              data_addr <= src_ptr + STEP;
              state     <= RD;
            end
          end
        end
`endif

        FIN: begin
          data_stb <= 1'b0;
          data_we  <= 1'b0;
          if (done) begin
            state <= IDLE;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          data_stb <= 1'b0;
          data_we  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memcopy.sv
// Directed self-checking bench for memcopy with a zero-wait memory responder.
// Expectations follow MEMCOPY_VERIFY_EN the same way the design does.
module tb_memcopy;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] src_addr;
  logic [26:0] dst_addr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        error;
  logic [26:0] err_addr;
  logic        data_stb;
  logic        data_we;
  logic [26:0] data_addr;
  logic [31:0] data_dout;
  logic [31:0] data_din;
  logic        data_ack;
  logic        data_timeout;

  int checks = 0;
  int errors = 0;

`ifdef MEMCOPY_VERIFY_EN
  localparam bit VFY_ON = 1'b1;
`else
  localparam bit VFY_ON = 1'b0;
`endif

  logic [31:0] mem [logic [26:0]];
  logic [26:0] rd_log [$];
  bit          op_log [$];
  int          wr_count;
  bit          tmo_arm;
  logic [26:0] tmo_addr;
  bit          corrupt_arm;
  logic [26:0] corrupt_addr;

  memcopy dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_addr     (err_addr),
    .data_stb     (data_stb),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_dout    (data_dout),
    .data_din     (data_din),
    .data_ack     (data_ack),
    .data_timeout (data_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait responder: answers one cycle after seeing a request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ack     <= 1'b0;
      data_timeout <= 1'b0;
      data_din     <= '0;
    end else begin
      data_ack     <= 1'b0;
      data_timeout <= 1'b0;
      if (data_stb && !data_ack && !data_timeout) begin
        if (tmo_arm && !data_we && data_addr == tmo_addr) begin
          data_timeout <= 1'b1;
        end else begin
          data_ack <= 1'b1;
          op_log.push_back(data_we);
          if (data_we) begin
            wr_count = wr_count + 1;
            mem[data_addr] = (corrupt_arm && data_addr == corrupt_addr) ? (data_dout ^ 32'h1) : data_dout;
          end else begin
            rd_log.push_back(data_addr);
            data_din <= mem.exists(data_addr) ? mem[data_addr] : 32'h0;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    op_log.delete();
    wr_count     = 0;
    tmo_arm      = 1'b0;
    corrupt_arm  = 1'b0;
  endtask

  task automatic run_copy(input logic [26:0] s, input logic [26:0] d, input logic [15:0] c,
                          output int cyc, output bit stb_seen);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    count    = c;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    stb_seen = 1'b0;
    while (!done && cyc < 400) begin
      if (data_stb) stb_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL done_wait: done=%0b after %0d cycles, required done=1", done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({busy, done, error, data_stb, data_we} !== 5'b0 || err_addr !== 27'h0 ||
        data_addr !== 27'h0 || data_dout !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%0b done=%0b error=%0b stb=%0b we=%0b err_addr=%h addr=%h dout=%h, required all 0",
               busy, done, error, data_stb, data_we, err_addr, data_addr, data_dout);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_copy();
    int cyc;
    bit stb_seen;
    int bad;
    clear_logs();
    run_copy(27'h0000100, 27'h0000200, 16'd4, cyc, stb_seen);
    checks++;
    if (cyc !== (VFY_ON ? 25 : 17)) begin
      errors++;
      $display("[TB] FAIL basic_done_cycle: got %0d, required %0d", cyc, VFY_ON ? 25 : 17);
    end
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_status: error=%0b busy=%0b, required 0/0", error, busy);
    end
    checks++;
    if (mem[27'h200] !== 32'h11111111 || mem[27'h204] !== 32'h22222222 ||
        mem[27'h208] !== 32'h33333333 || mem[27'h20C] !== 32'h44444444) begin
      errors++;
      $display("[TB] FAIL basic_dest_data: %h %h %h %h, required 11111111 22222222 33333333 44444444",
               mem[27'h200], mem[27'h204], mem[27'h208], mem[27'h20C]);
    end
    bad = 0;
    for (int i = 0; i < op_log.size(); i++) begin
      if (op_log[i] !== (VFY_ON ? (i % 3 == 1) : (i % 2 == 1))) bad++;
    end
    checks++;
    if (bad != 0 || op_log.size() != (VFY_ON ? 12 : 8) || wr_count != 4) begin
      errors++;
      $display("[TB] FAIL basic_op_order: ops=%0d writes=%0d bad_order=%0d, required ops=%0d writes=4 bad_order=0",
               op_log.size(), wr_count, bad, VFY_ON ? 12 : 8);
    end
  endtask

  task automatic test_zero_count();
    int cyc;
    bit stb_seen;
    clear_logs();
    run_copy(27'h0000100, 27'h0000300, 16'd0, cyc, stb_seen);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("[TB] FAIL zero_done_cycle: got %0d, required 2", cyc);
    end
    checks++;
    if (stb_seen !== 1'b0 || op_log.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_no_bus: stb_seen=%0b ops=%0d, required 0/0", stb_seen, op_log.size());
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit stb_seen;
    clear_logs();
    tmo_arm  = 1'b1;
    tmo_addr = 27'h0000104;
    run_copy(27'h0000100, 27'h0000600, 16'd4, cyc, stb_seen);
    checks++;
    if (error !== 1'b1 || err_addr !== 27'h0000104) begin
      errors++;
      $display("[TB] FAIL timeout_error: error=%0b err_addr=%h, required 1 / 0000104", error, err_addr);
    end
    checks++;
    if (data_stb !== 1'b0 || wr_count != 1) begin
      errors++;
      $display("[TB] FAIL timeout_abort: stb=%0b writes=%0d, required 0 / 1", data_stb, wr_count);
    end
    tmo_arm = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    bit stb_seen;
    clear_logs();
    run_copy(27'h7FFFFFC, 27'h0001000, 16'd2, cyc, stb_seen);
    checks++;
    if (rd_log.size() < 2 || rd_log[0] !== 27'h7FFFFFC ||
        rd_log[VFY_ON ? 2 : 1] !== 27'h0000000) begin
      errors++;
      $display("[TB] FAIL wrap_read_addrs: reads=%0d first=%h, required 7ffffff c then 0000000",
               rd_log.size(), rd_log.size() > 0 ? rd_log[0] : 27'h0);
    end
    checks++;
    if (error !== 1'b0 || mem[27'h1000] !== 32'hDEADBEEF || mem[27'h1004] !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL wrap_result: error=%0b d0=%h d1=%h, required 0 deadbeef cafef00d",
               error, mem[27'h1000], mem[27'h1004]);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int cyc;
    int n;
    bit stb_seen;
    clear_logs();
    @(negedge clk);
    src_addr = 27'h0000300;
    dst_addr = 27'h0000400;
    count    = 16'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(data_stb && data_we && data_addr == 27'h0000408) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL midreset_reach_word3: not reached in %0d cycles, required write at 0000408", n);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_stb !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: stb=%0b busy=%0b, required 0/0", data_stb, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    run_copy(27'h0000300, 27'h0000500, 16'd2, cyc, stb_seen);
    checks++;
    if (error !== 1'b0 || wr_count != 2 || mem[27'h500] !== 32'hA0A0A0A0 || mem[27'h504] !== 32'hA1A1A1A1) begin
      errors++;
      $display("[TB] FAIL midreset_restart: error=%0b writes=%0d d0=%h d1=%h, required 0 2 a0a0a0a0 a1a1a1a1",
               error, wr_count, mem[27'h500], mem[27'h504]);
    end
  endtask

  task automatic test_verify();
    int cyc;
    bit stb_seen;
    clear_logs();
    corrupt_arm  = 1'b1;
    corrupt_addr = 27'h0000208;
    run_copy(27'h0000100, 27'h0000200, 16'd4, cyc, stb_seen);
    checks++;
    if (error !== VFY_ON || (VFY_ON && err_addr !== 27'h0000208)) begin
      errors++;
      $display("[TB] FAIL verify_result: error=%0b err_addr=%h, required error=%0b err_addr=0000208",
               error, err_addr, VFY_ON);
    end
    corrupt_arm = 1'b0;
  endtask

  initial begin
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    count    = '0;
    clear_logs();
    mem[27'h100]     = 32'h11111111;
    mem[27'h104]     = 32'h22222222;
    mem[27'h108]     = 32'h33333333;
    mem[27'h10C]     = 32'h44444444;
    mem[27'h7FFFFFC] = 32'hDEADBEEF;
    mem[27'h0000000] = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) mem[27'h300 + 27'(4 * i)] = 32'hA0A0A0A0 + 32'h01010101 * 32'(i);

    test_reset();
    test_basic_copy();
    test_zero_count();
    test_timeout();
    test_wrap();
    test_reset_mid_transfer();
    test_verify();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
